// File: rtl/music_rom_reader.sv
// -----------------------------------------------------------------------------
// music_rom_reader
//
// Playback engine for the sample ROM. Walks the inclusive address range
// [start_addr, end_addr] at one sample every CLK_DIV clocks, registers each ROM
// byte as the current audio sample and turns it into a 1-bit PWM stream.
// Supports play, pause, stop and looping.
//
// Ports:
//   i_clk          system clock, all state changes on its rising edge
//   i_reset_n      synchronous active-low reset
//   i_play         start request, only looked at while idle
//   i_pause        freezes the sample timer while high
//   i_stop         aborts playback (no done pulse)
//   i_loop_en      restart at start instead of finishing, sampled at the end
//   i_start_addr   first sample address, latched on start
//   i_end_addr     last sample address (inclusive), latched on start
//   o_rom_addr     registered ROM address
//   i_rom_data     combinational ROM data for o_rom_addr
//   o_sample       current audio sample
//   o_sample_valid one-cycle pulse when a new sample is registered
//   o_pwm_out      registered PWM audio output
//   o_busy         high whenever playback is in progress
//   o_done         one-cycle pulse on natural end (or empty range request)
// -----------------------------------------------------------------------------
module music_rom_reader #(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 6250,
    parameter logic [DATA_W-1:0] IDLE_LEVEL = 8'h80
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [DATA_W-1:0] i_rom_data,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_valid,
    output logic              o_pwm_out,
    output logic              o_busy,
    output logic              o_done
);

    // Divider holds at most CLK_DIV-2, so clog2(CLK_DIV) bits always suffice.
    localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivReload = DivW'(CLK_DIV - 2);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StWait
    } state_e;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_start;
    logic [ADDR_W-1:0]   r_end;
    logic [DivW-1:0]     r_div;
    logic [DATA_W-1:0]   r_sample;
    logic                r_valid;
    logic                r_done;
    logic [DATA_W-1:0]   r_pwm_cnt;
    logic                r_pwm;

    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   w_start_nxt;
    logic [ADDR_W-1:0]   w_end_nxt;
    logic [DivW-1:0]     w_div_nxt;
    logic [DATA_W-1:0]   w_sample_nxt;
    logic                w_valid_nxt;
    logic                w_done_nxt;

    // State register and all other sequential state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_start   <= '0;
            r_end     <= '0;
            r_div     <= '0;
            r_sample  <= IDLE_LEVEL;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_pwm_cnt <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_start   <= w_start_nxt;
            r_end     <= w_end_nxt;
            r_div     <= w_div_nxt;
            r_sample  <= w_sample_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
            r_pwm_cnt <= r_pwm_cnt + DATA_W'(1);
            r_pwm     <= (r_pwm_cnt < r_sample);
        end
    end

    // Next-state logic. Stop beats pause; neither affects IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_start_nxt  = r_start;
        w_end_nxt    = r_end;
        w_div_nxt    = r_div;
        w_sample_nxt = r_sample;
        w_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_play) begin
                    if (i_start_addr <= i_end_addr) begin
                        w_start_nxt = i_start_addr;
                        w_end_nxt   = i_end_addr;
                        w_addr_nxt  = i_start_addr;
                        w_state_nxt = StFetch;
                    end else begin
                        // Empty range: report completion without fetching.
                        w_done_nxt = 1'b1;
                    end
                end
            end

            StFetch: begin
                if (i_stop) begin
                    w_state_nxt  = StIdle;
                    w_sample_nxt = IDLE_LEVEL;
                end else begin
                    // Pause does not block a fetch already under way.
                    w_sample_nxt = i_rom_data;
                    w_valid_nxt  = 1'b1;
                    w_div_nxt    = DivReload;
                    w_state_nxt  = StWait;
                end
            end

            StWait: begin
                if (i_stop) begin
                    w_state_nxt  = StIdle;
                    w_sample_nxt = IDLE_LEVEL;
                end else if (!i_pause) begin
                    if (r_div != '0) begin
                        w_div_nxt = r_div - DivW'(1);
                    end else if (r_addr != r_end) begin
                        // Only incremented while below end, so never wraps.
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = StFetch;
                    end else if (i_loop_en) begin
                        w_addr_nxt  = r_start;
                        w_state_nxt = StFetch;
                    end else begin
                        w_state_nxt  = StIdle;
                        w_sample_nxt = IDLE_LEVEL;
                        w_done_nxt   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt  = StIdle;
                w_sample_nxt = IDLE_LEVEL;
            end
        endcase
    end

    assign o_rom_addr     = r_addr;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;
    assign o_pwm_out      = r_pwm;
    assign o_busy         = (r_state != StIdle);
    assign o_done         = r_done;

endmodule

// File: tb/tb_music_rom_reader.sv
module tb_music_rom_reader;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CLK_DIV = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              play = 1'b0;
    logic              pause = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              pwm_out;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    music_rom_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .IDLE_LEVEL(8'h80)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_play        (play),
        .i_pause       (pause),
        .i_stop        (stop),
        .i_loop_en     (loop_en),
        .i_start_addr  (start_addr),
        .i_end_addr    (end_addr),
        .o_rom_addr    (rom_addr),
        .i_rom_data    (rom_data),
        .o_sample      (sample),
        .o_sample_valid(sample_valid),
        .o_pwm_out     (pwm_out),
        .o_busy        (busy),
        .o_done        (done)
    );

    // ROM image
    function automatic logic [7:0] rom_img(input logic [ADDR_W-1:0] a);
        case (a)
            24'd0:     return 8'h55;
            24'd1:     return 8'h5C;
            24'd5:     return 8'h85;
            24'd100:   return 8'h00;
            24'd20000: return 8'h33;
            24'd41000: return 8'h40;
            default:   return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    assign rom_data = rom_img(rom_addr);

    // Reference model: counts edges remaining until the next sample is registered.
    logic              m_active = 1'b0;
    int                m_togo = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [ADDR_W-1:0] m_lo = '0;
    logic [ADDR_W-1:0] m_hi = '0;
    logic [7:0]        m_sample = 8'h80;
    logic              m_valid = 1'b0;
    logic              m_done = 1'b0;
    logic [7:0]        m_cnt = 8'h00;
    logic              m_pwm = 1'b0;

    task automatic model_edge();
        logic nxt_pwm;
        nxt_pwm = (m_cnt < m_sample);
        m_cnt   = m_cnt + 8'd1;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (!reset_n) begin
            m_active = 1'b0;
            m_addr   = '0;
            m_lo     = '0;
            m_hi     = '0;
            m_sample = 8'h80;
            m_cnt    = 8'h00;
            m_pwm    = 1'b0;
            return;
        end
        if (!m_active) begin
            if (play) begin
                if (start_addr <= end_addr) begin
                    m_active = 1'b1;
                    m_lo     = start_addr;
                    m_hi     = end_addr;
                    m_addr   = start_addr;
                    m_togo   = 1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (stop) begin
            m_active = 1'b0;
            m_sample = 8'h80;
        end else if (m_togo == 1) begin
            m_sample = rom_img(m_addr);
            m_valid  = 1'b1;
            m_togo   = CLK_DIV;
        end else if (!pause) begin
            m_togo = m_togo - 1;
            if (m_togo == 1) begin
                if (m_addr != m_hi) begin
                    m_addr = m_addr + 1;
                end else if (loop_en) begin
                    m_addr = m_lo;
                end else begin
                    m_active = 1'b0;
                    m_sample = 8'h80;
                    m_done   = 1'b1;
                end
            end
        end
        m_pwm = nxt_pwm;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("sample", 32'(sample), 32'(m_sample));
        check("sample_valid", 32'(sample_valid), 32'(m_valid));
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
    endtask

    typedef struct {
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] e;
        logic              lp;
        int                cycles;
        int                exp_valids;
        int                exp_dones;
        logic [7:0]        exp_last;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int nv, nd, k, highs;

        vecs[0] = '{24'd0, 24'd1, 1'b0, 12, 2, 1, 8'h80};
        vecs[1] = '{24'd5, 24'd5, 1'b1, 13, 4, 0, 8'h85};
        vecs[2] = '{24'd6, 24'd5, 1'b0, 6, 0, 1, 8'h80};
        vecs[3] = '{24'd41000, 24'd41000, 1'b0, 3, 1, 0, 8'h40};
        vecs[4] = '{24'd20000, 24'd20002, 1'b0, 20, 3, 1, 8'h80};
        vecs[5] = '{24'hFFFFFE, 24'hFFFFFF, 1'b0, 12, 2, 1, 8'h80};

        // Reset held while play toggles
        reset_n = 1'b0;
        start_addr = 24'd0;
        end_addr = 24'd1;
        for (int i = 0; i < 3; i++) begin
            play = ~play;
            step();
        end
        check("reset rom_addr", 32'(rom_addr), 32'd0);
        check("reset sample", 32'(sample), 32'h80);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset valid", 32'(sample_valid), 32'd0);
        check("reset pwm", 32'(pwm_out), 32'd0);
        play = 1'b0;
        reset_n = 1'b1;
        step();

        // Table-driven playbacks
        foreach (vecs[i]) begin
            start_addr = vecs[i].s;
            end_addr = vecs[i].e;
            loop_en = vecs[i].lp;
            play = 1'b1;
            step();
            play = 1'b0;
            nv = int'(sample_valid);
            nd = int'(done);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                nv += int'(sample_valid);
                nd += int'(done);
            end
            check($sformatf("vec%0d valids", i), 32'(nv), 32'(vecs[i].exp_valids));
            check($sformatf("vec%0d dones", i), 32'(nd), 32'(vecs[i].exp_dones));
            check($sformatf("vec%0d last sample", i), 32'(sample), 32'(vecs[i].exp_last));
            stop = 1'b1;
            step();
            stop = 1'b0;
            check($sformatf("vec%0d stopped busy", i), 32'(busy), 32'd0);
            step();
        end

        // Pause for 10 cycles in the middle of WAIT
        start_addr = 24'd20000;
        end_addr = 24'd20001;
        loop_en = 1'b0;
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        check("pause first sample", 32'(sample), 32'h33);
        step();
        pause = 1'b1;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            nv += int'(sample_valid);
        end
        check("pause valids", 32'(nv), 32'd0);
        check("pause busy", 32'(busy), 32'd1);
        check("pause addr frozen", 32'(rom_addr), 32'd20000);
        pause = 1'b0;
        k = 0;
        while (k < 8) begin
            step();
            k++;
            if (sample_valid) break;
        end
        check("resume latency", 32'(k), 32'd3);
        check("resume sample", 32'(sample), 32'(rom_img(24'd20001)));
        for (int c = 0; c < 8; c++) step();
        check("pause run finished", 32'(busy), 32'd0);

        // Loop, then clear loop_en: finishes after the current sample
        start_addr = 24'd5;
        end_addr = 24'd5;
        loop_en = 1'b1;
        play = 1'b1;
        step();
        play = 1'b0;
        for (int c = 0; c < 6; c++) step();
        loop_en = 1'b0;
        k = 0;
        nv = 0;
        while (k < 10) begin
            step();
            k++;
            nv += int'(sample_valid);
            if (done) break;
        end
        check("loop clear steps to done", 32'(k), 32'd2);
        check("loop clear extra valids", 32'(nv), 32'd0);
        check("loop clear sample", 32'(sample), 32'h80);
        step();

        // Stop during WAIT; play while busy is ignored
        start_addr = 24'd41000;
        end_addr = 24'd41000;
        loop_en = 1'b1;
        play = 1'b1;
        step();
        start_addr = 24'd0;
        end_addr = 24'd1;
        step();
        play = 1'b0;
        check("busy play ignored addr", 32'(rom_addr), 32'd41000);
        check("stop pre sample", 32'(sample), 32'h40);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop busy", 32'(busy), 32'd0);
        check("stop sample", 32'(sample), 32'h80);
        check("stop done", 32'(done), 32'd0);
        check("stop addr holds", 32'(rom_addr), 32'd41000);
        step();

        // Play held across a natural finish restarts on the next cycle
        start_addr = 24'd5;
        end_addr = 24'd5;
        loop_en = 1'b0;
        play = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("held play done", 32'(done), 32'd1);
        check("held play idle", 32'(busy), 32'd0);
        step();
        play = 1'b0;
        check("held play restart", 32'(busy), 32'd1);
        step();
        check("held play valid", 32'(sample_valid), 32'd1);
        for (int c = 0; c < 6; c++) step();

        // PWM duty: 0x40 -> 64 highs per 256, 0x00 -> none
        for (int p = 0; p < 2; p++) begin
            start_addr = (p == 0) ? 24'd41000 : 24'd100;
            end_addr = start_addr;
            loop_en = 1'b1;
            play = 1'b1;
            step();
            play = 1'b0;
            for (int c = 0; c < 8; c++) step();
            highs = 0;
            for (int c = 0; c < 256; c++) begin
                step();
                highs += int'(pwm_out);
            end
            check($sformatf("pwm highs sample%0d", p), 32'(highs), (p == 0) ? 32'd64 : 32'd0);
            stop = 1'b1;
            step();
            stop = 1'b0;
            step();
        end

        // Randomised traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [ADDR_W-1:0] pool[6];
            pool = '{24'd0, 24'd5, 24'd100, 24'd20000, 24'd41000, 24'hFFFFFD};
            reset_n = ($urandom_range(0, 199) != 0);
            play = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 4) == 0);
            stop = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) loop_en = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                start_addr = pool[$urandom_range(0, 5)];
                end_addr = start_addr + ADDR_W'($urandom_range(0, 3)) - ADDR_W'(1);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/music_rom_reader.md
Name: music_rom_reader

Overview:
- Playback engine on the read side of ROM_musicas (24-bit address, 8-bit combinational data).
- Walks an address range [start_addr, end_addr] at a fixed sample rate and registers each byte as the current audio sample.
- Drives a 1-bit PWM audio output and reports progress to the player control logic.
- Supports play, pause, stop and loop.

Parameters:
ADDR_W, 24, ROM address width
DATA_W, 8, sample width; PWM counter width equals DATA_W
CLK_DIV, 6250, clock cycles per sample (50 MHz / 8 kHz); legal range >= 2
IDLE_LEVEL, 8'h80, mid-scale sample held while not playing

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
play  input  1  level; sampled in IDLE only, starts playback
pause  input  1  level; freezes playback while high
stop  input  1  level; aborts playback
loop_en  input  1  restart at start_addr after end_addr instead of finishing
start_addr  input  ADDR_W  first sample address; latched on start
end_addr  input  ADDR_W  last sample address, inclusive; latched on start
rom_addr  output  ADDR_W  registered address to ROM_musicas
rom_data  input  DATA_W  ROM data for rom_addr, valid the same cycle
sample  output  DATA_W  current audio sample (registered)
sample_valid  output  1  one-cycle pulse when sample updates
pwm_out  output  1  registered PWM audio
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on natural end of non-looping playback

Behaviour:
- Synchronous active-low reset. When reset_n=0 at a clk edge:
  - state=IDLE, rom_addr=0, sample=IDLE_LEVEL, sample_valid=0, busy=0, done=0, pwm_out=0.
  - divider=0, PWM counter=0, latched start/end=0.
  - Reset mid-playback aborts identically, with no done pulse.
- Priority each cycle: reset > stop > pause > normal operation.
- States: IDLE, FETCH, WAIT.
- IDLE:
  - play=1 with start_addr<=end_addr: latch start/end, rom_addr<=start_addr, go to FETCH.
  - play=1 with start_addr>end_addr: pulse done for one cycle, stay in IDLE, rom_addr unchanged.
- FETCH (one cycle, rom_addr already stable):
  - sample<=rom_data, sample_valid<=1 for exactly the next cycle.
  - divider<=CLK_DIV-2, go to WAIT.
- WAIT:
  - divider!=0: decrement.
  - divider==0 and rom_addr!=end: rom_addr<=rom_addr+1, go to FETCH.
  - divider==0, rom_addr==end, loop_en=1: rom_addr<=latched start, go to FETCH.
  - divider==0, rom_addr==end, loop_en=0: go to IDLE, sample<=IDLE_LEVEL, done pulses one cycle.
  - loop_en is sampled at the end decision, not at start.
- Timing:
  - sample_valid pulses are exactly CLK_DIV cycles apart during steady playback.
  - First sample_valid comes 2 cycles after the edge that samples play=1 (one edge to enter FETCH, one to register the sample).
- Address never wraps: it increments only while != end, so end_addr=24'hFFFFFF is legal.
- pause=1:
  - In WAIT: divider, rom_addr and sample freeze; busy stays 1.
  - In FETCH: the fetch completes, then WAIT freezes.
  - In IDLE: no effect.
  - Release resumes with the remaining divider count, without losing or repeating a sample.
- stop=1 outside IDLE: next state IDLE, sample<=IDLE_LEVEL, sample_valid=0, no done pulse, rom_addr holds. stop in IDLE: no effect.
- play while busy is ignored. start_addr/end_addr changes during playback are ignored (latched copies are used).
- play held high after a natural finish restarts playback on the following cycle.
- PWM:
  - Free-running DATA_W-bit counter, increments every cycle and wraps 255->0.
  - pwm_out<=(counter<sample), unsigned compare, registered.
  - sample=0 gives a constant low output; sample=255 gives 255 high cycles per 256.

Test Plan (CLK_DIV=4; ROM_musicas image: [0]=8'h55, [1]=8'h5C, [5]=8'h85, [20000]=8'h33, [41000]=8'h40):
- Reset: hold reset_n=0 for 3 cycles while toggling play -> rom_addr=0, sample=8'h80, busy=0, done=0, sample_valid=0, pwm_out=0.
- Play start=0, end=1, loop_en=0:
  - sample=8'h55 with valid 2 cycles after play is sampled, then 8'h5C exactly 4 cycles later.
  - 4 cycles after that: done pulses once, busy=0, sample=8'h80.
- Loop start=end=5, loop_en=1: sample_valid every 4 cycles, sample=8'h85 each time, no done pulse. Clear loop_en -> finishes after the current sample with done.
- Pause held 10 cycles mid-WAIT over start=20000, end=20001: no sample_valid while paused. After release, the 8'h33->next transition arrives at the remaining divider count.
- Stop during WAIT at addr 41000 (sample 8'h40): next cycle busy=0, sample=8'h80, done=0. play during busy ignored. start=6, end=5 -> immediate done pulse, no fetch.
- PWM: force sample=8'h40 via start=end=41000 -> pwm_out high 64 of every 256 cycles. A 0x00 sample gives no highs.
